// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM state encoding, the rotating-priority pick and the watchdog width.
package wb_arb_pkg;

   localparam int unsigned MAX_MASTERS = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
   function automatic int unsigned wd_width(input int unsigned timeout_cycles);
      return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

   // First requester scanning from last+1, modulo n; result is one-hot.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(
      input logic [MAX_MASTERS-1:0] req,
      input logic [1:0]             last,
      input int unsigned            n
   );
      logic [MAX_MASTERS-1:0] gnt;
      logic [1:0]             idx;
      gnt = '0;
      for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
         if (i <= n) begin
            idx = 2'((32'(last) + i) % n);
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [MAX_MASTERS-1:0] oh);
      logic [1:0] idx;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer stall watchdog: counts strobed cycles without a termination and
// emits a one-cycle timeout pulse when the limit is reached.
module wb_arb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic term,
   input  logic enable,
   output logic timeout
);

   localparam int unsigned          WD_W  = wd_width(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]      LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] count;
   logic            at_limit;

   // A termination in the limit cycle wins, so term blocks the fire.
   assign at_limit = enable && active && !term && (count == LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= at_limit;
         if (!enable || !active || term || at_limit) begin
            count <= '0;
         end else begin
            count <= count + WD_W'(1);
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave port among up to
// four masters, with a stall watchdog that terminates hung transfers with err.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_MASTERS-1:0]              m_cyc_i,
   input  logic [NUM_MASTERS-1:0]              m_stb_i,
   input  logic [NUM_MASTERS-1:0]              m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
   output logic [DATA_WIDTH-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]              m_ack_o,
   output logic [NUM_MASTERS-1:0]              m_err_o,
   output logic [NUM_MASTERS-1:0]              m_rty_o,
   output logic                                s_cyc_o,
   output logic                                s_stb_o,
   output logic                                s_we_o,
   output logic [ADDR_WIDTH-1:0]               s_adr_o,
   output logic [DATA_WIDTH-1:0]               s_dat_o,
   output logic [DATA_WIDTH/8-1:0]             s_sel_o,
   input  logic [DATA_WIDTH-1:0]               s_dat_i,
   input  logic                                s_ack_i,
   input  logic                                s_err_i,
   input  logic                                s_rty_i,
   output logic [NUM_MASTERS-1:0]              grant_o,
   output logic                                timeout_o
);

   localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

   arb_state_t             state;
   logic [NUM_MASTERS-1:0] grant;
   logic [1:0]             last_grant;
   logic [MAX_MASTERS-1:0] cyc_ext, stb_ext, we_ext, pick;
   logic [ADDR_WIDTH-1:0]  adr_arr [MAX_MASTERS];
   logic [DATA_WIDTH-1:0]  dat_arr [MAX_MASTERS];
   logic [SEL_WIDTH-1:0]   sel_arr [MAX_MASTERS];
   logic                   busy, wd_kill, term_any;
   logic                   err_t, ack_t, rty_t;

   // Pad the per-master buses to MAX_MASTERS so a 2-bit index is always legal.
   for (genvar k = 0; k < MAX_MASTERS; k++) begin : g_unpack
      if (k < NUM_MASTERS) begin : g_used
         assign cyc_ext[k] = m_cyc_i[k];
         assign stb_ext[k] = m_stb_i[k];
         assign we_ext[k]  = m_we_i[k];
         assign adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         assign dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         assign sel_arr[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end else begin : g_unused
         assign cyc_ext[k] = 1'b0;
         assign stb_ext[k] = 1'b0;
         assign we_ext[k]  = 1'b0;
         assign adr_arr[k] = '0;
         assign dat_arr[k] = '0;
         assign sel_arr[k] = '0;
      end
   end

   assign pick = rr_pick(cyc_ext, last_grant, NUM_MASTERS);

   // last_grant doubles as the owner index while BUSY.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= 2'(NUM_MASTERS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|m_cyc_i) begin
                  grant      <= pick[NUM_MASTERS-1:0];
                  last_grant <= onehot_idx(pick);
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (!cyc_ext[last_grant]) begin
                  grant <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy     = (state == BUSY);
   assign grant_o  = grant;
   assign m_dat_o  = s_dat_i;

   assign s_cyc_o  = busy & cyc_ext[last_grant];
   assign s_stb_o  = busy & stb_ext[last_grant] & ~wd_kill;
   assign s_we_o   = busy & we_ext[last_grant];
   assign s_adr_o  = busy ? adr_arr[last_grant] : '0;
   assign s_dat_o  = busy ? dat_arr[last_grant] : '0;
   assign s_sel_o  = busy ? sel_arr[last_grant] : '0;

   // One termination per cycle: err (slave or watchdog) > ack > rty.
   assign err_t    = busy & (s_err_i | wd_kill);
   assign ack_t    = busy & s_ack_i & ~err_t;
   assign rty_t    = busy & s_rty_i & ~err_t & ~s_ack_i;
   assign m_err_o  = {NUM_MASTERS{err_t}} & grant;
   assign m_ack_o  = {NUM_MASTERS{ack_t}} & grant;
   assign m_rty_o  = {NUM_MASTERS{rty_t}} & grant;

   assign term_any  = s_ack_i | s_err_i | s_rty_i;
   assign timeout_o = wd_kill;

   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk_i),
      .rst     (rst_i),
      .active  (busy & s_stb_o),
      .term    (term_any),
      .enable  (TIMEOUT_CYCLES != 0),
      .timeout (wd_kill)
   );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (2 masters, 8-cycle watchdog).
module tb_wb_rr_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM-1:0]     m_cyc, m_stb, m_we;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic [NM*DW/8-1:0] m_sel;
   logic [DW-1:0]     m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [DW/8-1:0]   s_sel_o;
   logic [DW-1:0]     s_dat;
   logic              s_ack, s_err, s_rty;
   logic [NM-1:0]     grant_o;
   logic              timeout_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [1:0] order [8];

   wb_rr_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .m_cyc_i   (m_cyc),
      .m_stb_i   (m_stb),
      .m_we_i    (m_we),
      .m_adr_i   (m_adr),
      .m_dat_i   (m_dat),
      .m_sel_i   (m_sel),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rty_o   (m_rty_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_dat_i   (s_dat),
      .s_ack_i   (s_ack),
      .s_err_i   (s_err),
      .s_rty_i   (s_rty),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_adr = {32'h0000_0020, 32'h0000_0010};
      m_dat = {32'h1234_5678, 32'hDEAD_BEEF};
      m_sel = {4'hF, 4'h3};
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

      // Reset state
      tick; tick;
      chk("rst_grant", grant_o, 0);
      chk("rst_scyc", s_cyc_o, 0);
      chk("rst_sstb", s_stb_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_ack", m_ack_o, 0);
      rst = 1'b0;

      // Single read by master 0, two wait states
      m_cyc = 2'b01; m_stb = 2'b01;
      #1;
      chk("t1_scyc_pre", s_cyc_o, 0);
      tick;
      chk("t1_grant", grant_o, 2'b01);
      chk("t1_scyc", s_cyc_o, 1);
      chk("t1_sstb", s_stb_o, 1);
      chk("t1_adr", s_adr_o, 32'h10);
      chk("t1_wait1", m_ack_o, 0);
      tick;
      chk("t1_wait2", m_ack_o, 0);
      tick;
      s_ack = 1'b1; s_dat = 32'hCAFE_0010;
      #1;
      chk("t1_ack", m_ack_o, 2'b01);
      chk("t1_rdata", m_dat_o, 32'hCAFE_0010);
      tick;
      s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
      #1;
      chk("t1_ack_done", m_ack_o, 0);
      chk("t1_scyc_drop", s_cyc_o, 0);
      chk("t1_grant_hold", grant_o, 2'b01);
      tick;
      chk("t1_grant_idle", grant_o, 0);

      // Both masters contend, 4 transfers each
      rst = 1'b1; tick; rst = 1'b0;
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int t = 0; t < 8; t++) begin
         tick;
         chk("t2_grant", grant_o, order[t]);
         s_ack = 1'b1;
         #1;
         chk("t2_ack", m_ack_o, order[t]);
         tick;
         s_ack = 1'b0;
         m_cyc = m_cyc & ~order[t];
         m_stb = m_stb & ~order[t];
         #1;
         chk("t2_scyc_drop", s_cyc_o, 0);
         tick;
         chk("t2_dead", grant_o, 0);
         if (t < 6) begin
            m_cyc = m_cyc | order[t];
            m_stb = m_stb | order[t];
         end
      end

      // Master 1 holds cyc over three strobes while master 0 waits
      m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
      tick;
      chk("t3_grant", grant_o, 2'b10);
      chk("t3_adr", s_adr_o, 32'h20);
      chk("t3_we", s_we_o, 1);
      chk("t3_wdata", s_dat_o, 32'h1234_5678);
      chk("t3_sel", s_sel_o, 4'hF);
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int s = 0; s < 3; s++) begin
         s_ack = 1'b1;
         #1;
         chk("t3_ack", m_ack_o, 2'b10);
         tick;
         s_ack = 1'b0;
         m_stb = 2'b01;
         #1;
         chk("t3_hold", grant_o, 2'b10);
         chk("t3_stb_gap", s_stb_o, 0);
         tick;
         if (s < 2) m_stb = 2'b11;
      end
      m_cyc = 2'b01; m_we = 2'b00;
      tick;
      chk("t3_dead", grant_o, 0);
      tick;
      chk("t3_m0_grant", grant_o, 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick; tick;

      // Watchdog: slave never terminates
      m_cyc = 2'b01; m_stb = 2'b01;
      tick;
      chk("t4_grant", grant_o, 2'b01);
      for (int k = 1; k <= 8; k++) begin
         chk("t4_stall_err", m_err_o, 0);
         chk("t4_stall_to", timeout_o, 0);
         tick;
      end
      chk("t4_timeout", timeout_o, 1);
      chk("t4_err", m_err_o, 2'b01);
      chk("t4_kill", s_stb_o, 0);
      chk("t4_no_ack", m_ack_o, 0);
      tick;
      chk("t4_retry_stb", s_stb_o, 1);
      chk("t4_retry_to", timeout_o, 0);
      chk("t4_retry_err", m_err_o, 0);
      for (int k = 11; k <= 17; k++) begin
         tick;
         chk("t4_restall_to", timeout_o, 0);
      end
      tick;
      chk("t4_timeout2", timeout_o, 1);
      chk("t4_err2", m_err_o, 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick; tick;

      // Ack on the last allowed stall cycle beats the watchdog
      m_cyc = 2'b10; m_stb = 2'b10;
      tick;
      chk("t5_grant", grant_o, 2'b10);
      for (int k = 1; k <= 7; k++) begin
         chk("t5_stall_err", m_err_o, 0);
         tick;
      end
      s_ack = 1'b1;
      #1;
      chk("t5_ack", m_ack_o, 2'b10);
      chk("t5_no_err", m_err_o, 0);
      tick;
      s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
      #1;
      chk("t5_no_timeout", timeout_o, 0);
      chk("t5_no_err_after", m_err_o, 0);
      tick; tick;

      // Reset during a stalled transfer owned by master 1
      m_cyc = 2'b10; m_stb = 2'b10;
      tick;
      chk("t6_grant", grant_o, 2'b10);
      tick; tick;
      rst = 1'b1;
      tick;
      chk("t6_grant_drop", grant_o, 0);
      chk("t6_scyc", s_cyc_o, 0);
      chk("t6_timeout", timeout_o, 0);
      chk("t6_no_err", m_err_o, 0);
      chk("t6_no_ack", m_ack_o, 0);
      m_cyc = 2'b11; m_stb = 2'b11;
      rst = 1'b0;
      tick;
      chk("t6_m0_first", grant_o, 2'b01);
      m_cyc = 2'b00; m_stb = 2'b00;
      tick; tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
